// File: rtl/kamacore_hazard_unit.sv
// Hazard detection, stall/bubble generation and operand-forward selection for the kamacore pipeline.
// Define KAMACORE_HAZARD_FORWARDING_EN to enable EX-operand forwarding; otherwise every RAW hazard stalls.
module kamacore_hazard_unit #(
  parameter int CPU_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CPU_WIDTH-1:0]      id_instruction,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_destination_register,
  input  logic                      ex_control_write_register,
  input  logic                      ex_control_memory_read,
  input  logic [REG_ADDR_WIDTH-1:0] mem_destination_register,
  input  logic                      mem_control_write_register,
  input  logic                      mem_control_memory_read,
  input  logic                      mem_control_memory_write,
  input  logic [REG_ADDR_WIDTH-1:0] wb_destination_register,
  input  logic                      wb_control_write_register,
  input  logic                      dmem_ready,
  output logic                      hold_if,
  output logic                      hold_id,
  output logic                      hold_ex,
  output logic                      hold_mem,
  output logic                      bubble_ex,
  output logic                      bubble_wb,
  output logic [1:0]                forward_rs1_sel,
  output logic [1:0]                forward_rs2_sel,
  output logic [31:0]               stall_cycles,
  output logic                      mem_fault
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {
    S_RUN,
    S_MEM_WAIT
  } state_t;

  state_t              state, next_state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [REG_ADDR_WIDTH-1:0] id_rs1, id_rs2;
  logic                id_match_ex, id_match_mem, id_match_wb;
  logic                load_use, data_hazard, mem_access, mem_stall;
  logic                unused_bits;

  function automatic logic match(input logic wr, input logic [REG_ADDR_WIDTH-1:0] rd,
                                 input logic [REG_ADDR_WIDTH-1:0] r);
    return wr && (rd == r) && (r != '0);
  endfunction

  assign id_rs1 = id_instruction[15 +: REG_ADDR_WIDTH];
  assign id_rs2 = id_instruction[20 +: REG_ADDR_WIDTH];

  assign id_match_ex  = (id_uses_rs1 && match(ex_control_write_register, ex_destination_register, id_rs1)) ||
                        (id_uses_rs2 && match(ex_control_write_register, ex_destination_register, id_rs2));
  assign id_match_mem = (id_uses_rs1 && match(mem_control_write_register, mem_destination_register, id_rs1)) ||
                        (id_uses_rs2 && match(mem_control_write_register, mem_destination_register, id_rs2));
  assign id_match_wb  = (id_uses_rs1 && match(wb_control_write_register, wb_destination_register, id_rs1)) ||
                        (id_uses_rs2 && match(wb_control_write_register, wb_destination_register, id_rs2));

  assign load_use = id_match_ex && ex_control_memory_read;

`ifdef KAMACORE_HAZARD_FORWARDING_EN
  assign data_hazard = load_use;
`else
  assign data_hazard = id_match_ex || id_match_mem || id_match_wb;
`endif

  assign mem_access = mem_control_memory_read || mem_control_memory_write;
  // Stall from the very cycle an unfinished access appears; a ready in MEM_WAIT is the release cycle.
  assign mem_stall  = !dmem_ready && (mem_access || (state == S_MEM_WAIT));

  assign unused_bits = ^{id_instruction, ex_rs1, ex_rs2};

  always_comb begin
    // NOTE: every output gets a default before any branch so no path can infer a latch.
    next_state = state;
    hold_if    = 1'b0;
    hold_id    = 1'b0;
    hold_ex    = 1'b0;
    hold_mem   = 1'b0;
    bubble_ex  = 1'b0;
    bubble_wb  = 1'b0;

    unique case (state)
      S_RUN:      if (mem_access && !dmem_ready) next_state = S_MEM_WAIT;
      S_MEM_WAIT: if (dmem_ready)                next_state = S_RUN;
      default:                                   next_state = S_RUN;
    endcase

    if (mem_stall) begin
      hold_if   = 1'b1;
      hold_id   = 1'b1;
      hold_ex   = 1'b1;
      hold_mem  = 1'b1;
      bubble_wb = 1'b1;
    end else if (data_hazard) begin
      // Also evaluated in the release cycle so a pending load-use is not lost.
      hold_if   = 1'b1;
      hold_id   = 1'b1;
      bubble_ex = 1'b1;
    end
  end

`ifdef KAMACORE_HAZARD_FORWARDING_EN
  always_comb begin
    forward_rs1_sel = 2'b00;
    forward_rs2_sel = 2'b00;
    if (match(mem_control_write_register, mem_destination_register, ex_rs1))
      forward_rs1_sel = 2'b01;
    else if (match(wb_control_write_register, wb_destination_register, ex_rs1))
      forward_rs1_sel = 2'b10;
    if (match(mem_control_write_register, mem_destination_register, ex_rs2))
      forward_rs2_sel = 2'b01;
    else if (match(wb_control_write_register, wb_destination_register, ex_rs2))
      forward_rs2_sel = 2'b10;
  end
`else
  assign forward_rs1_sel = 2'b00;
  assign forward_rs2_sel = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RUN;
      wait_cnt     <= '0;
      stall_cycles <= '0;
      mem_fault    <= 1'b0;
    end else begin
      state <= next_state;
      if (mem_stall) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == WAIT_LAST) mem_fault <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (hold_if && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: doc/kamacore_hazard_unit.md
# kamacore_hazard_unit

Pipeline control block that reads the contents of the ID, EX, MEM and WB stage interfaces and drives their `hold` inputs. It also generates bubble and operand-forwarding selects. It detects read-after-write and load-use hazards and freezes the pipeline while the data memory has not completed a request. It keeps a saturating stall-cycle counter and a memory-timeout fault flag.

## Interface
- `CPU_WIDTH`, 32, datapath width
- `REG_ADDR_WIDTH`, 5, register address width
- `MEM_TIMEOUT`, 255, maximum dmem wait cycles before fault

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `id_instruction`  in  CPU_WIDTH  ID-stage instruction; rs1 = [19:15], rs2 = [24:20]
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  ID instruction reads that operand
- `ex_rs1`, `ex_rs2`  in  REG_ADDR_WIDTH each  EX-stage source registers
- `ex_destination_register`  in  REG_ADDR_WIDTH  EX rd
- `ex_control_write_register`, `ex_control_memory_read`  in  1 each  EX control bits
- `mem_destination_register`  in  REG_ADDR_WIDTH  MEM rd
- `mem_control_write_register`, `mem_control_memory_read`, `mem_control_memory_write`  in  1 each  MEM control bits
- `wb_destination_register`  in  REG_ADDR_WIDTH  WB rd
- `wb_control_write_register`  in  1  WB control bit
- `dmem_ready`  in  1  data memory completes the current MEM access this cycle
- `hold_if`, `hold_id`, `hold_ex`, `hold_mem`  out  1 each  stage holds
- `bubble_ex`, `bubble_wb`  out  1 each  load a NOP (all control bits 0) into EX / WB next edge
- `forward_rs1_sel`, `forward_rs2_sel`  out  2 each  00 regfile, 01 MEM `ex_result`, 10 WB result, 11 unused
- `stall_cycles`  out  32  saturating count of cycles with `hold_if` = 1
- `mem_fault`  out  1  sticky dmem timeout flag

## Operation
- Register x0 never produces a hazard or a forward.
- Match(stage, r) = stage write_register & stage rd == r & r != 0, evaluated for r in {rs1 if used, rs2 if used}.
- FSM states RUN and MEM_WAIT; reset state RUN.
- RUN → MEM_WAIT: MEM has read|write & !dmem_ready.
- MEM_WAIT → RUN: dmem_ready = 1.
- MEM_WAIT requires `hold_if`=`hold_id`=`hold_ex`=`hold_mem`=1, `bubble_wb`=1, `bubble_ex`=0. The combinational stall is asserted in the same cycle the condition first appears, not one cycle later.
- Load-use: in RUN, Match(EX, ID rs) & `ex_control_memory_read` requires `hold_if`=`hold_id`=1 and `bubble_ex`=1.
- Memory stall has priority over load-use; load-use is re-evaluated after release.
- Forwarding targets the EX operands: Match(MEM, ex_rsN) gives 01, else Match(WB, ex_rsN) gives 10, else 00. MEM wins over WB.
- Wait counter: cleared in RUN, +1 per MEM_WAIT cycle. Reaching `MEM_TIMEOUT` sets `mem_fault`, which stays set until `rst`. The FSM keeps waiting.
- `stall_cycles` saturates at 0xFFFF_FFFF.

## Timing
- Holds, bubbles and forward selects are combinational from the inputs and the state register, with zero latency.
- State, wait counter, `stall_cycles` and `mem_fault` update on `clk`.
- A load-use stall lasts exactly 1 cycle. The consumer then enters EX with the load in WB and forward = 10.
- With `dmem_ready`=1 in the same cycle the access is presented, there is no stall.
- `rst` mid-MEM_WAIT: next state RUN, counters 0, `mem_fault` 0.
- Reset values:
  - all holds and bubbles 0
  - forward selects 00
  - `stall_cycles` 0
  - `mem_fault` 0

## Configuration
- `KAMACORE_HAZARD_FORWARDING_EN` defined: forwarding as above; only load-use and memory stalls occur.
- Undefined:
  - forward selects tied to 00
  - any Match(EX|MEM|WB, ID rs) in RUN asserts `hold_if`=`hold_id`=1 and `bubble_ex`=1
  - a dependent instruction waits until the writer has left WB (up to 3 cycles)

## Test plan
- EX add x5 writes, next instruction in EX reads x5 via MEM → `forward_rs1_sel`=01. WB-only match on rs2 → 10. Both MEM and WB write x5 → 01. rd=x0 → 00.
- EX lw x7, ID add reads x7 → one cycle of `hold_if`=`hold_id`=`bubble_ex`=1; next cycle forward=10; `stall_cycles`=1.
- MEM sw with `dmem_ready` low for 4 cycles → all holds and `bubble_wb` high for exactly 4 cycles, RUN on the 5th.
- `dmem_ready` low for 255 cycles → `mem_fault`=1 and stays 1 after ready returns, until `rst`.
- `rst` asserted during MEM_WAIT → next cycle all outputs 0 and state RUN.
- Macro undefined: ID reads x3 while MEM writes x3 → stall until the writer leaves WB (2 cycles), selects 00.
